// File: rtl/aes_key_expand_seq.sv
// aes_key_expand_seq: word-serial AES-128/192/256 key schedule with a round-key read port; ports: clk/rst, key_in/key_mode/start load, busy/ready status, rk_req/rk_idx/rk_dec -> rk_valid/rk_out, sticky err
module aes_key_expand_seq #(
  parameter int MAX_KEY = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [0:MAX_KEY-1] key_in,
  input  logic [1:0]         key_mode,
  input  logic               start,
  output logic               busy,
  output logic               ready,
  input  logic               rk_req,
  input  logic [3:0]         rk_idx,
  input  logic               rk_dec,
  output logic               rk_valid,
  output logic [0:127]       rk_out,
  output logic               err
);
  localparam int NR_MAX = MAX_KEY == 128 ? 10 : MAX_KEY == 192 ? 12 : 14;
  localparam int WD = 4 * (NR_MAX + 1);
  localparam int NKM = MAX_KEY / 32;
  typedef enum logic [1:0] {IDLE, GEN, RDY} state_t;
  state_t state;
  logic [31:0] w [0:WD-1];
  logic [7:0] rcon;
  logic [5:0] i, tot, base;
  logic [3:0] j, nk, nr, nk_new, nr_new, r;
  logic legal, go, last, bad;
  logic [31:0] prev, tw, nw;
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = '0;
    x = a;
    y = b;
    for (int k = 0; k < 8; k++) begin
      p = y[0] ? p ^ x : p;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction
  // S-box computed as GF(2^8) inverse (x^254) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] p, q;
    p = gmul(a, a);
    q = p;
    for (int k = 0; k < 6; k++) begin
      p = gmul(p, p);
      q = gmul(q, p);
    end
    return q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]} ^ 8'h63;
  endfunction
  function automatic logic [31:0] subw(input logic [31:0] a);
    return {sbox(a[31:24]), sbox(a[23:16]), sbox(a[15:8]), sbox(a[7:0])};
  endfunction
  assign busy = state == GEN;
  assign ready = state == RDY;
  always_comb begin
    nk_new = key_mode == 2'd0 ? 4'd4 : key_mode == 2'd1 ? 4'd6 : 4'd8;
    nr_new = nk_new + 4'd6;
    legal = key_mode == 2'd0 || (key_mode == 2'd1 && MAX_KEY >= 192) || (key_mode == 2'd2 && MAX_KEY >= 256);
    go = start && legal && state != GEN;
    tot = {nr + 4'd1, 2'b00};
    last = i == tot - 6'd1;
    // j tracks i mod Nk so Nk=6 needs no divider
    prev = w[i - 6'd1];
    tw = j == 4'd0 ? subw({prev[23:0], prev[31:24]}) ^ {rcon, 24'h0} : (nk == 4'd8 && j == 4'd4) ? subw(prev) : prev;
    nw = w[i - {2'b00, nk}] ^ tw;
    bad = rk_idx > nr;
    r = rk_dec ? nr - rk_idx : rk_idx;
    base = {r, 2'b00};
  end
  always_ff @(posedge clk) begin
    if (go) begin
      for (int k = 0; k < NKM; k++)
        if (k < int'(nk_new)) w[6'(k)] <= key_in[32*k +: 32];
    end else if (state == GEN) w[i] <= nw;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rcon <= 8'h01;
      i <= '0;
      j <= '0;
      nk <= 4'd4;
      nr <= 4'd10;
      err <= 1'b0;
      rk_valid <= 1'b0;
      rk_out <= '0;
    end else begin
      rk_valid <= 1'b0;
      if (start && state != GEN && !legal) err <= 1'b1;
      if (go) begin
        state <= GEN;
        nk <= nk_new;
        nr <= nr_new;
        i <= {2'b00, nk_new};
        j <= '0;
        rcon <= 8'h01;
        err <= 1'b0;
      end else if (state == GEN) begin
        i <= i + 6'd1;
        j <= j == nk - 4'd1 ? 4'd0 : j + 4'd1;
        if (j == 4'd0) rcon <= xt(rcon);
        if (last) state <= RDY;
      end
      if (rk_req && state == RDY) begin
        rk_valid <= 1'b1;
        rk_out <= bad ? '0 : {w[base], w[base + 6'd1], w[base + 6'd2], w[base + 6'd3]};
        if (bad) err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_aes_key_expand_seq.sv
// tb_aes_key_expand_seq: directed FIPS-197 vectors and control corner cases for aes_key_expand_seq
module tb_aes_key_expand_seq;
  logic clk = 0, rst = 1, start = 0, rk_req = 0, rk_dec = 0;
  logic [0:255] key_in = '0;
  logic [1:0] key_mode = '0;
  logic [3:0] rk_idx = '0;
  logic busy, ready, rk_valid, err;
  logic [0:127] rk_out;
  int checks = 0, failures = 0, n;
  logic [127:0] rk128 [0:10];
  logic [0:255] k128, k192, k256;
  logic [127:0] held;
  aes_key_expand_seq #(.MAX_KEY(256)) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_mode(key_mode), .start(start),
    .busy(busy), .ready(ready), .rk_req(rk_req), .rk_idx(rk_idx), .rk_dec(rk_dec),
    .rk_valid(rk_valid), .rk_out(rk_out), .err(err)
  );
  always #5 clk = ~clk;
  task automatic do_start(input logic [0:255] k, input logic [1:0] m);
    @(negedge clk);
    start = 1;
    key_in = k;
    key_mode = m;
    @(negedge clk);
    start = 0;
  endtask
  task automatic wait_busy(output int cnt);
    cnt = 0;
    while (busy && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
  endtask
  task automatic do_read(input logic [3:0] idx, input logic dec);
    rk_req = 1;
    rk_idx = idx;
    rk_dec = dec;
    @(negedge clk);
    rk_req = 0;
  endtask
  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready got %b exp 0", ready); end
    checks++; if (rk_valid !== 1'b0) begin failures++; $display("FAIL reset_rk_valid got %b exp 0", rk_valid); end
    checks++; if (rk_out !== 128'h0) begin failures++; $display("FAIL reset_rk_out got %h exp 0", rk_out); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got %b exp 0", err); end
    rst = 0;
    @(negedge clk);
  endtask
  task automatic test_aes128;
    do_start(k128, 2'd0);
    wait_busy(n);
    checks++; if (n != 40) begin failures++; $display("FAIL aes128_busy_cycles got %0d exp 40", n); end
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL aes128_ready got %b exp 1", ready); end
    do_read(4'd1, 1'b0);
    checks++; if (rk_valid !== 1'b1) begin failures++; $display("FAIL aes128_r1_valid got %b exp 1", rk_valid); end
    checks++; if (rk_out !== 128'ha0fafe1788542cb123a339392a6c7605) begin failures++; $display("FAIL aes128_r1 got %h exp a0fafe1788542cb123a339392a6c7605", rk_out); end
    do_read(4'd10, 1'b0);
    checks++; if (rk_out !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin failures++; $display("FAIL aes128_r10 got %h exp d014f9a8c9ee2589e13f0cc8b6630ca6", rk_out); end
    do_read(4'd0, 1'b1);
    checks++; if (rk_out !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin failures++; $display("FAIL aes128_dec0 got %h exp d014f9a8c9ee2589e13f0cc8b6630ca6", rk_out); end
    held = rk_out;
    @(negedge clk);
    checks++; if (rk_valid !== 1'b0) begin failures++; $display("FAIL aes128_valid_pulse got %b exp 0", rk_valid); end
    checks++; if (rk_out !== held) begin failures++; $display("FAIL aes128_hold got %h exp %h", rk_out, held); end
  endtask
  task automatic test_back_to_back;
    rk_req = 1;
    rk_dec = 0;
    rk_idx = 4'd0;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      checks++; if (rk_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid[%0d] got %b exp 1", k, rk_valid); end
      checks++; if (rk_out !== rk128[k]) begin failures++; $display("FAIL b2b_key[%0d] got %h exp %h", k, rk_out, rk128[k]); end
      if (k < 10) rk_idx = 4'(k + 1); else rk_req = 0;
    end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL b2b_err got %b exp 0", err); end
  endtask
  task automatic test_bad_idx;
    do_read(4'd11, 1'b0);
    checks++; if (rk_valid !== 1'b1) begin failures++; $display("FAIL bad_idx_valid got %b exp 1", rk_valid); end
    checks++; if (rk_out !== 128'h0) begin failures++; $display("FAIL bad_idx_out got %h exp 0", rk_out); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL bad_idx_err got %b exp 1", err); end
  endtask
  task automatic test_aes192;
    do_start(k192, 2'd1);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL aes192_err_clear got %b exp 0", err); end
    wait_busy(n);
    checks++; if (n != 46) begin failures++; $display("FAIL aes192_busy_cycles got %0d exp 46", n); end
    do_read(4'd0, 1'b1);
    checks++; if (rk_out !== 128'he98ba06f448c773c8ecc720401002202) begin failures++; $display("FAIL aes192_r12 got %h exp e98ba06f448c773c8ecc720401002202", rk_out); end
  endtask
  task automatic test_illegal_mode;
    @(negedge clk);
    start = 1;
    key_mode = 2'd3;
    @(negedge clk);
    start = 0;
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL mode3_err got %b exp 1", err); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mode3_busy got %b exp 0", busy); end
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL mode3_ready got %b exp 1", ready); end
  endtask
  task automatic test_aes256;
    do_start(k256, 2'd2);
    wait_busy(n);
    checks++; if (n != 52) begin failures++; $display("FAIL aes256_busy_cycles got %0d exp 52", n); end
    do_read(4'd14, 1'b0);
    checks++; if (rk_out !== 128'hfe4890d1e6188d0b046df344706c631e) begin failures++; $display("FAIL aes256_r14 got %h exp fe4890d1e6188d0b046df344706c631e", rk_out); end
    do_read(4'd13, 1'b1);
    checks++; if (rk_out !== k256[128:255]) begin failures++; $display("FAIL aes256_dec13 got %h exp %h", rk_out, k256[128:255]); end
  endtask
  task automatic test_req_busy;
    do_start(k128, 2'd0);
    rk_req = 1;
    rk_idx = 4'd1;
    repeat (5) begin
      @(negedge clk);
      checks++; if (rk_valid !== 1'b0) begin failures++; $display("FAIL busy_req_valid got %b exp 0", rk_valid); end
    end
    rk_req = 0;
    wait_busy(n);
    checks++; if (n != 35) begin failures++; $display("FAIL busy_req_remaining got %0d exp 35", n); end
  endtask
  task automatic test_start_while_busy;
    do_start(k128, 2'd0);
    n = 0;
    while (busy && n < 200) begin
      start = n == 10;
      key_in = n == 10 ? k256 : k128;
      key_mode = n == 10 ? 2'd2 : 2'd0;
      n++;
      @(negedge clk);
    end
    start = 0;
    checks++; if (n != 40) begin failures++; $display("FAIL restart_busy_cycles got %0d exp 40", n); end
    do_read(4'd10, 1'b0);
    checks++; if (rk_out !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin failures++; $display("FAIL restart_busy_r10 got %h exp d014f9a8c9ee2589e13f0cc8b6630ca6", rk_out); end
  endtask
  task automatic test_rst_mid;
    do_start(k128, 2'd0);
    repeat (20) @(negedge clk);
    #2 rst = 1;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL rst_ready got %b exp 0", ready); end
    checks++; if (rk_out !== 128'h0) begin failures++; $display("FAIL rst_rk_out got %h exp 0", rk_out); end
    checks++; if (rk_valid !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL rst_valid_err got %b%b exp 00", rk_valid, err); end
    @(negedge clk);
    rst = 0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0 || ready !== 1'b0) begin failures++; $display("FAIL rst_idle got %b%b exp 00", busy, ready); end
    do_start(k128, 2'd0);
    wait_busy(n);
    checks++; if (n != 40) begin failures++; $display("FAIL rst_restart_cycles got %0d exp 40", n); end
    do_read(4'd10, 1'b0);
    checks++; if (rk_out !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin failures++; $display("FAIL rst_restart_r10 got %h exp d014f9a8c9ee2589e13f0cc8b6630ca6", rk_out); end
  endtask
  initial begin
    k128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    k192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    k256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    rk128[0] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    rk128[1] = 128'ha0fafe1788542cb123a339392a6c7605;
    rk128[2] = 128'hf2c295f27a96b9435935807a7359f67f;
    rk128[3] = 128'h3d80477d4716fe3e1e237e446d7a883b;
    rk128[4] = 128'hef44a541a8525b7fb671253bdb0bad00;
    rk128[5] = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    rk128[6] = 128'h6d88a37a110b3efddbf98641ca0093fd;
    rk128[7] = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    rk128[8] = 128'head27321b58dbad2312bf5607f8d292f;
    rk128[9] = 128'hac7766f319fadc2128d12941575c006e;
    rk128[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    test_reset;
    test_aes128;
    test_back_to_back;
    test_bad_idx;
    test_aes192;
    test_illegal_mode;
    test_aes256;
    test_req_busy;
    test_start_while_busy;
    test_rst_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/aes_key_expand_seq.md
Name: aes_key_expand_seq

Overview:
Iterative, word-serial AES key expansion engine that generalises the fixed 128-bit, fully combinational round-key chain to AES-128/192/256, selected per operation. It generates one 32-bit schedule word per cycle into internal word storage and serves any 128-bit round key on request, in forward order (encryption) or reverse order (decryption). It sits between the key-load interface and the round datapath of the AES decryption/encryption cores.

Parameters:
MAX_KEY, 256, largest supported key length in bits: 128, 192 or 256. Sets key_in width and storage depth: 4*(Nr_max+1) words, i.e. 44, 52 or 60.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
key_in  in  [0:MAX_KEY-1]  cipher key, MSB-aligned; bit 0 = first key byte MSB
key_mode  in  2  0 = AES-128, 1 = AES-192, 2 = AES-256, 3 = reserved
start  in  1  begin expansion; key_in/key_mode sampled on this edge
busy  out  1  expansion in progress
ready  out  1  full schedule valid in storage
rk_req  in  1  round-key read request
rk_idx  in  4  round number 0..Nr
rk_dec  in  1  1: return key for round Nr-rk_idx
rk_valid  out  1  rk_out valid, single-cycle pulse
rk_out  out  [0:127]  round key, words w[4r]..w[4r+3], w[4r] in bits 0:31
err  out  1  sticky error flag

Behaviour:
- Reset: busy=0, ready=0, rk_valid=0, rk_out=0, err=0, rcon register=8'h01, word counter=0. Storage contents undefined.
- Nk/Nr: mode 0 = 4/10, mode 1 = 6/12, mode 2 = 8/14. Total words T = 4*(Nr+1) = 44/52/60.
- Mode validity: a mode is unsupported if it needs a key longer than MAX_KEY. Mode 3 or an unsupported mode with start: err=1, no expansion, ready/busy unchanged.
- start while busy=0 with a legal mode, at edge E0:
  - Load words w[0..Nk-1] from key_in[0:32*Nk-1].
  - Set busy=1, ready=0, err=0, rcon=01, i=Nk.
- Generation, one word per edge E1..E(T-Nk), i.e. 40/46/52 cycles:
  - t = w[i-1].
  - If i mod Nk = 0: t = SubWord(RotWord(t)) ^ {rcon,24'h0}. After use, rcon = xtime(rcon): left shift, XOR 8'h1b on carry.
  - Else if Nk=8 and i mod 8 = 4: t = SubWord(t).
  - w[i] = w[i-Nk] ^ t.
  - SubWord is four forward S-box lookups.
- At the edge writing w[T-1]: busy=0, ready=1 in the same cycle.
- start while busy=1: ignored.
- start while ready=1: restarts expansion. ready drops at E0; the old schedule is lost.
- Read port, 1-cycle latency:
  - rk_req sampled at edge N with ready=1: rk_valid=1 and rk_out = key for round r after edge N.
  - r = rk_dec ? Nr-rk_idx : rk_idx.
  - Back-to-back requests are allowed, one per cycle.
  - rk_req with ready=0: no response, rk_valid stays 0.
  - rk_idx > Nr: rk_valid=1, rk_out=0, err=1.
- rk_out holds its last value when rk_valid=0.
- err is cleared only by rst or by an accepted start.
- rst mid-expansion: immediate return to reset state. A new start is required.

Test Plan:
- AES-128 FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start:
  - busy high exactly 40 cycles, then ready=1.
  - Round 1 = a0fafe1788542cb123a339392a6c7605.
  - Round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- AES-192 key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
  - 46 busy cycles.
  - rk_idx=0, rk_dec=1 → round 12 = e98ba06f448c773c8ecc720401002202.
- AES-256 key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - 52 busy cycles.
  - Round 14 = fe4890d1e6188d0b046df344706c631e.
  - Verifies the i mod 8 = 4 SubWord path.
- Read port edge cases:
  - rk_req on consecutive cycles with idx 0..10 → 11 consecutive rk_valid pulses with matching keys.
  - rk_req during busy → no rk_valid.
  - rk_idx=11 in mode 0 → rk_out=0, err=1.
- Control edge cases:
  - start mode 3 → err=1, busy stays 0.
  - start while busy → ignored; completion stays at the original cycle count.
  - Assert rst at generation cycle 20 → all outputs 0 asynchronously.
  - Restart → correct round-10 key.
